// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtraction controller: feeds operands LSB-first to one external
// full subtractor, carries the borrow between bits and assembles the difference.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             fs_a,
    output logic             fs_b,
    output logic             fs_bin,
    input  logic             fs_d,
    input  logic             fs_bout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        fs_a     = 1'b0;
        fs_b     = 1'b0;
        fs_bin   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                busy   = 1'b1;
                fs_a   = sa[0];
                fs_b   = sb[0];
                fs_bin = brw;
                if (last_bit) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, exactly as the hardware does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa   <= '0;
            sb   <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // diff/bout keep the previous result until the new one shifts in
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        brw <= bin;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sa   <= sa >> 1;
                    sb   <= sb >> 1;
                    brw  <= fs_bout;
                    diff <= {fs_d, diff[WIDTH-1:1]};
                    cnt  <= cnt + 1'b1;
                    if (last_bit) bout <= fs_bout;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Bench for serial_subtractor_ctrl: behavioural full subtractor on the fs_* loop,
// expected results queued at issue time and popped when done pulses.
module tb_serial_subtractor_ctrl;

    localparam int WIDTH = 8;
    localparam int TMO   = 3 * WIDTH;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             bout;
    } result_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             bin = 1'b0;
    logic             fs_a, fs_b, fs_bin, fs_d, fs_bout;
    logic             busy, done, bout;
    logic [WIDTH-1:0] diff;

    result_t sb_q[$];
    int      vectors = 0;
    int      miscompares = 0;

    always #5 clk = ~clk;

    assign fs_d    = fs_a ^ fs_b ^ fs_bin;
    assign fs_bout = (~fs_a & fs_b) | (~(fs_a ^ fs_b) & fs_bin);

    serial_subtractor_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .fs_a(fs_a), .fs_b(fs_b), .fs_bin(fs_bin), .fs_d(fs_d), .fs_bout(fs_bout),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
    );

    function automatic result_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                      input logic bi);
        logic [WIDTH:0] r;
        r = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, bi};
        model.diff = r[WIDTH-1:0];
        model.bout = r[WIDTH];
    endfunction

    // Drive operands with start, queue the expectation, consume the accept edge.
    task automatic issue_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic bi);
        a = x; b = y; bin = bi; start = 1'b1;
        sb_q.push_back(model(x, y, bi));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit seen, output int cycles);
        seen = 0;
        cycles = 0;
        while (!seen && cycles < TMO) begin
            @(posedge clk); #1;
            cycles++;
            if (done) seen = 1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        vectors++;
        if ({busy, done, diff, bout, fs_a, fs_b, fs_bin} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b diff=%h bout=%b fs=%b%b%b, want all 0",
                     busy, done, diff, bout, fs_a, fs_b, fs_bin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_latency;
        int edges = 0, busy_cnt = 0, done_cnt = 0, done_at = 0;
        result_t exp_r;
        logic fs_at_done = 1'b1;
        a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
        sb_q.push_back(model(8'h05, 8'h03, 1'b0));
        while (edges < WIDTH + 4) begin
            @(posedge clk); #1;
            start = 1'b0;
            edges++;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = edges;
                fs_at_done = fs_a | fs_b | fs_bin;
                exp_r = sb_q.pop_front();
                vectors++;
                if (diff !== exp_r.diff || bout !== exp_r.bout) begin
                    miscompares++;
                    $display("FAIL basic_05_03: diff=%h bout=%b, want diff=%h bout=%b",
                             diff, bout, exp_r.diff, exp_r.bout);
                end
            end
        end
        vectors++;
        if (done_at != WIDTH + 1 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL done_latency: done at edge %0d count %0d, want edge %0d count 1",
                     done_at, done_cnt, WIDTH + 1);
        end
        vectors++;
        if (busy_cnt != WIDTH + 1) begin
            miscompares++;
            $display("FAIL busy_cycles: %0d, want %0d", busy_cnt, WIDTH + 1);
        end
        vectors++;
        if (fs_at_done !== 1'b0) begin
            miscompares++;
            $display("FAIL fs_zero_in_done: fs_a|fs_b|fs_bin=%b, want 0", fs_at_done);
        end
    endtask

    task automatic test_vectors;
        logic [WIDTH-1:0] va[4] = '{8'h03, 8'h00, 8'hFF, 8'h80};
        logic [WIDTH-1:0] vb[4] = '{8'h05, 8'h00, 8'hFF, 8'h01};
        logic             vi[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        bit seen;
        int cyc;
        result_t exp_r;
        for (int i = 0; i < 4; i++) begin
            issue_op(va[i], vb[i], vi[i]);
            wait_done(seen, cyc);
            exp_r = sb_q.pop_front();
            vectors++;
            if (!seen || diff !== exp_r.diff || bout !== exp_r.bout) begin
                miscompares++;
                $display("FAIL vector_%0d: seen=%0b diff=%h bout=%b, want diff=%h bout=%b",
                         i, seen, diff, bout, exp_r.diff, exp_r.bout);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_start_while_busy;
        int done_cnt = 0;
        result_t exp_r;
        logic fs_idle;
        issue_op(8'h05, 8'h03, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        a = 8'h10; b = 8'h01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < TMO && done_cnt == 0; i++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        fs_idle = fs_a | fs_b | fs_bin;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        exp_r = sb_q.pop_front();
        vectors++;
        if (done_cnt != 1) begin
            miscompares++;
            $display("FAIL busy_start_done_count: %0d, want 1", done_cnt);
        end
        vectors++;
        if (diff !== exp_r.diff || bout !== exp_r.bout || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_start_ignored: diff=%h bout=%b busy=%b, want diff=%h bout=%b busy=0",
                     diff, bout, busy, exp_r.diff, exp_r.bout);
        end
        vectors++;
        if (fs_idle !== 1'b0) begin
            miscompares++;
            $display("FAIL fs_zero_in_idle: %b, want 0", fs_idle);
        end
    endtask

    task automatic test_reset_mid_run;
        bit seen;
        int cyc;
        result_t exp_r;
        a = 8'hAA; b = 8'h11; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, diff, bout, fs_a, fs_b, fs_bin} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_run: busy=%b done=%b diff=%h bout=%b fs=%b%b%b, want all 0",
                     busy, done, diff, bout, fs_a, fs_b, fs_bin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue_op(8'h09, 8'h04, 1'b0);
        wait_done(seen, cyc);
        exp_r = sb_q.pop_front();
        vectors++;
        if (!seen || diff !== exp_r.diff || bout !== exp_r.bout) begin
            miscompares++;
            $display("FAIL after_reset_09_04: seen=%0b diff=%h bout=%b, want diff=%h bout=%b",
                     seen, diff, bout, exp_r.diff, exp_r.bout);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        bit seen;
        int cyc;
        int spacing_bad = 0;
        int val_bad = 0;
        logic [WIDTH-1:0] x, y;
        logic bi;
        result_t exp_r;
        x = WIDTH'($urandom); y = WIDTH'($urandom); bi = 1'($urandom);
        a = x; b = y; bin = bi; start = 1'b1;
        sb_q.push_back(model(x, y, bi));
        for (int i = 0; i < 1000; i++) begin
            wait_done(seen, cyc);
            if (!seen) begin
                vectors++;
                miscompares++;
                $display("FAIL sweep_timeout: op %0d no done within %0d cycles", i, TMO);
                break;
            end
            exp_r = sb_q.pop_front();
            vectors++;
            if (diff !== exp_r.diff || bout !== exp_r.bout) begin
                miscompares++;
                val_bad++;
                if (val_bad <= 5)
                    $display("FAIL sweep_value op %0d: diff=%h bout=%b, want diff=%h bout=%b",
                             i, diff, bout, exp_r.diff, exp_r.bout);
            end
            if (i > 0) begin
                vectors++;
                if (cyc != WIDTH + 2) begin
                    miscompares++;
                    spacing_bad++;
                    if (spacing_bad <= 5)
                        $display("FAIL sweep_spacing op %0d: %0d cycles, want %0d", i, cyc, WIDTH + 2);
                end
            end
            if (i < 999) begin
                x = WIDTH'($urandom); y = WIDTH'($urandom); bi = 1'($urandom);
                a = x; b = y; bin = bi;
                sb_q.push_back(model(x, y, bi));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d left, want 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_vectors();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
